// File: rtl/flappy_matrix_core_if.sv
// Control and display signals of the flappy matrix core.
// The master side drives buttons and enable. The slave side (the core) drives the scan outputs.
interface flappy_matrix_core_if #(
  parameter int GS      = 8,
  parameter int SCORE_W = 8
);
  logic               ena;
  logic               btn_up;
  logic               btn_down;
  logic               mode;
  logic [GS-1:0]      col;
  logic [GS-1:0]      row;
  logic [SCORE_W-1:0] score;
  logic               game_over;

  modport master (output ena, btn_up, btn_down, mode,
                  input  col, row, score, game_over);
  modport slave  (input  ena, btn_up, btn_down, mode,
                  output col, row, score, game_over);
endinterface

// File: rtl/flappy_matrix_core.sv
// Flappy-bird game core for a GS x GS LED matrix. The bird sits in column 1 and one pipe scrolls left.
// The matrix is scanned one column per enabled cycle. Game state advances once per tick.
module flappy_matrix_core #(
  parameter int GS       = 8,
  parameter int TICK_DIV = 1000,
  parameter int GAP      = 3,
  parameter int SCORE_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,  // asynchronous, active-high in spite of its name
  flappy_matrix_core_if.slave bus
);

  localparam int PW = $clog2(GS);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] POS_TOP  = PW'(GS - 1);
  localparam logic [PW-1:0] POS_MID  = PW'(GS / 2);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PW-1:0] GAP_EXT  = PW'(GAP - 1);
  localparam logic [7:0]    GAP_SPAN = 8'(GS - GAP + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      tick_cnt;
  logic               tick;
  logic               up_p, down_p;
  logic [7:0]         lfsr;
  logic [7:0]         lfsr_mod;
  logic [PW-1:0]      col_idx;
  logic [PW-1:0]      bird_y, pipe_x, gap_y;
  logic [PW-1:0]      bird_nxt, pipe_nxt, gap_nxt;
  logic [SCORE_W-1:0] score, score_nxt;
  logic               ground_hit, pipe_hit;
  logic [GS-1:0]      row_pix;

  assign tick     = bus.ena && (tick_cnt == CW'(TICK_DIV - 1));
  assign lfsr_mod = lfsr % GAP_SPAN;

  // Tick divider, button latches, scan counter and LFSR: these run in every state.
  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    if (rst_n) begin
      tick_cnt <= '0;
      col_idx  <= '0;
      up_p     <= 1'b0;
      down_p   <= 1'b0;
      lfsr     <= 8'hA5;
    end else if (bus.ena) begin
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      col_idx  <= (col_idx == POS_TOP) ? '0 : col_idx + POS_ONE;
      // A press during the tick cycle itself stays latched for the next tick.
      up_p     <= bus.btn_up   | (up_p   & ~tick);
      down_p   <= bus.btn_down | (down_p & ~tick);
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)     state <= IDLE;
    else if (tick) state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bird_y <= POS_MID;
      pipe_x <= POS_TOP;
      gap_y  <= POS_ONE;
      score  <= '0;
    end else if (tick) begin
      bird_y <= bird_nxt;
      pipe_x <= pipe_nxt;
      gap_y  <= gap_nxt;
      score  <= score_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    bird_nxt   = bird_y;
    pipe_nxt   = pipe_x;
    gap_nxt    = gap_y;
    score_nxt  = score;
    ground_hit = 1'b0;
    pipe_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (up_p || down_p) begin
          state_nxt = RUN;
          bird_nxt  = POS_MID;
          pipe_nxt  = POS_TOP;
          gap_nxt   = POS_ONE;
          score_nxt = '0;
        end
      end
      RUN: begin
        if (bus.mode) begin
          if (up_p) begin
            if (bird_y != POS_TOP) bird_nxt = bird_y + POS_ONE;
          end else if (bird_y == '0) begin
            ground_hit = 1'b1;
          end else begin
            bird_nxt = bird_y - POS_ONE;
          end
        end else if (up_p && !down_p) begin
          if (bird_y != POS_TOP) bird_nxt = bird_y + POS_ONE;
        end else if (down_p && !up_p) begin
          if (bird_y != '0) bird_nxt = bird_y - POS_ONE;
        end

        if (pipe_x == '0) begin
          pipe_nxt = POS_TOP;
          gap_nxt  = PW'(lfsr_mod);
          if (score != '1) score_nxt = score + SCORE_W'(1);
        end else begin
          pipe_nxt = pipe_x - POS_ONE;
        end

        // Collision uses the post-move bird and pipe, so it is judged on what the next frame shows.
        pipe_hit = (pipe_nxt == POS_ONE) &&
                   ((bird_nxt < gap_nxt) || (bird_nxt > gap_nxt + GAP_EXT));
        if (ground_hit || pipe_hit) state_nxt = OVER;
      end
      OVER: begin
        if (up_p || down_p) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    row_pix = '0;
    if ((state != IDLE) && (col_idx == pipe_x)) begin
      for (int r = 0; r < GS; r++) begin
        row_pix[r] = (PW'(r) < gap_y) || (PW'(r) > gap_y + GAP_EXT);
      end
    end
    if (col_idx == POS_ONE) row_pix[bird_y] = 1'b1;

    bus.game_over = (state == OVER);
    bus.score     = score;
    bus.col       = bus.ena ? (GS'(1) << col_idx) : '0;
    bus.row       = bus.ena ? row_pix : '0;
  end

endmodule

// File: tb/tb_flappy_matrix_core.sv
// Directed bench for flappy_matrix_core with GS=8, TICK_DIV=4 and GAP=3.
// The tick phase, scan index and LFSR are tracked so that tick timing and the gap value are predicted independently.
module tb_flappy_matrix_core;
  localparam int GS = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;
  int   ph     = 0;
  int   cidx   = 0;
  logic [7:0] lf     = 8'hA5;
  logic [7:0] tick_lf = 8'hA5;
  int   gap_exp = 0;

  flappy_matrix_core_if #(.GS(GS), .SCORE_W(8)) bus ();

  flappy_matrix_core #(.GS(GS), .TICK_DIV(4), .GAP(3), .SCORE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    if (bus.ena) begin
      if (ph == 3) tick_lf = lf;
      ph   = (ph == 3) ? 0 : ph + 1;
      lf   = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      cidx = (cidx + 1) % GS;
    end
    #1;
  endtask

  task automatic run_tick(input logic up, input logic dn);
    bus.ena = 1'b1; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    if (ph == 3) cycle();
    bus.btn_up = up; bus.btn_down = dn;
    while (ph != 3) cycle();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    cycle();
  endtask

  task automatic apply_reset();
    bus.ena = 1'b1; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    ph = 0; cidx = 0; lf = 8'hA5;
  endtask

  task automatic test_reset();
    logic [7:0] exp_col, exp_row;
    bus.ena = 1'b1; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.mode = 1'b0;
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
    total++; if (bus.score !== 8'd0) $display("FAIL reset_score got %0d exp 0", bus.score); else passed++;
    total++; if (bus.game_over !== 1'b0) $display("FAIL reset_game_over got %b exp 0", bus.game_over); else passed++;
    total++; if (bus.col !== 8'h01) $display("FAIL reset_col got %h exp 01", bus.col); else passed++;
    total++; if (bus.row !== 8'h00) $display("FAIL reset_row got %h exp 00", bus.row); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b0; ph = 0; cidx = 0; lf = 8'hA5;
    for (int i = 0; i < GS; i++) begin
      cycle();
      exp_col = 8'(1) << cidx;
      exp_row = (cidx == 1) ? 8'h10 : 8'h00;
      total++; if (bus.col !== exp_col) $display("FAIL idle_scan_col got %h exp %h", bus.col, exp_col); else passed++;
      total++; if (bus.row !== exp_row) $display("FAIL idle_scan_row col %0d got %h exp %h", cidx, bus.row, exp_row); else passed++;
    end
    total++; if (int'(dut.state) !== 0) $display("FAIL idle_after_reset state %0d exp 0", dut.state); else passed++;
  endtask

  task automatic test_manual_saturation();
    int exp_b [5] = '{3, 2, 1, 0, 0};
    apply_reset();
    bus.mode = 1'b0;
    run_tick(1'b1, 1'b0);
    total++; if (int'(dut.state) !== 1) $display("FAIL man_start_state got %0d exp 1", dut.state); else passed++;
    total++; if (int'(dut.bird_y) !== 4) $display("FAIL man_start_bird got %0d exp 4", dut.bird_y); else passed++;
    total++; if (int'(dut.pipe_x) !== 7) $display("FAIL man_start_pipe got %0d exp 7", dut.pipe_x); else passed++;
    for (int i = 0; i < 5; i++) begin
      run_tick(1'b0, 1'b1);
      total++; if (int'(dut.bird_y) !== exp_b[i]) $display("FAIL man_down_bird tick %0d got %0d exp %0d", i + 1, dut.bird_y, exp_b[i]); else passed++;
      total++; if (bus.game_over !== 1'b0) $display("FAIL man_down_over tick %0d got %b exp 0", i + 1, bus.game_over); else passed++;
    end
    total++; if (int'(dut.pipe_x) !== 2) $display("FAIL man_pipe got %0d exp 2", dut.pipe_x); else passed++;
  endtask

  task automatic test_gravity_fall();
    int exp_b [4] = '{3, 2, 1, 0};
    apply_reset();
    bus.mode = 1'b1;
    run_tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_tick(1'b0, 1'b0);
      total++; if (int'(dut.bird_y) !== exp_b[i]) $display("FAIL grav_bird tick %0d got %0d exp %0d", i + 1, dut.bird_y, exp_b[i]); else passed++;
      total++; if (bus.game_over !== 1'b0) $display("FAIL grav_early_over tick %0d got %b exp 0", i + 1, bus.game_over); else passed++;
    end
    run_tick(1'b0, 1'b0);
    total++; if (bus.game_over !== 1'b1) $display("FAIL grav_ground_over got %b exp 1", bus.game_over); else passed++;
    total++; if (int'(dut.bird_y) !== 0) $display("FAIL grav_ground_bird got %0d exp 0", dut.bird_y); else passed++;
    total++; if (bus.score !== 8'd0) $display("FAIL grav_score got %0d exp 0", bus.score); else passed++;
    run_tick(1'b0, 1'b0);
    total++; if (bus.game_over !== 1'b1) $display("FAIL grav_over_hold got %b exp 1", bus.game_over); else passed++;
    run_tick(1'b0, 1'b1);
    total++; if (bus.game_over !== 1'b0) $display("FAIL grav_to_idle_over got %b exp 0", bus.game_over); else passed++;
    total++; if (int'(dut.state) !== 0) $display("FAIL grav_to_idle_state got %0d exp 0", dut.state); else passed++;
    bus.mode = 1'b0;
  endtask

  task automatic test_collision();
    logic [7:0] exp_col, exp_row;
    apply_reset();
    bus.mode = 1'b0;
    run_tick(1'b1, 1'b0);
    run_tick(1'b1, 1'b0);
    total++; if (int'(dut.bird_y) !== 5) $display("FAIL col_bird1 got %0d exp 5", dut.bird_y); else passed++;
    run_tick(1'b1, 1'b0);
    total++; if (int'(dut.bird_y) !== 6) $display("FAIL col_bird2 got %0d exp 6", dut.bird_y); else passed++;
    for (int t = 3; t <= 5; t++) begin
      run_tick(1'b0, 1'b0);
      total++; if (int'(dut.pipe_x) !== 7 - t) $display("FAIL col_pipe tick %0d got %0d exp %0d", t, dut.pipe_x, 7 - t); else passed++;
      total++; if (bus.game_over !== 1'b0) $display("FAIL col_early_over tick %0d got %b exp 0", t, bus.game_over); else passed++;
    end
    run_tick(1'b0, 1'b0);
    total++; if (int'(dut.pipe_x) !== 1) $display("FAIL col_hit_pipe got %0d exp 1", dut.pipe_x); else passed++;
    total++; if (bus.game_over !== 1'b1) $display("FAIL col_hit_over got %b exp 1", bus.game_over); else passed++;
    total++; if (bus.score !== 8'd0) $display("FAIL col_hit_score got %0d exp 0", bus.score); else passed++;
    // Frozen OVER frame: pipe in column 1 with gap rows 1..3, bird at row 6 hidden in the pipe.
    for (int i = 0; i < GS; i++) begin
      cycle();
      exp_col = 8'(1) << cidx;
      exp_row = (cidx == 1) ? 8'hF1 : 8'h00;
      total++; if (bus.col !== exp_col) $display("FAIL over_scan_col got %h exp %h", bus.col, exp_col); else passed++;
      total++; if (bus.row !== exp_row) $display("FAIL over_scan_row col %0d got %h exp %h", cidx, bus.row, exp_row); else passed++;
    end
    total++; if (bus.game_over !== 1'b1) $display("FAIL col_over_hold got %b exp 1", bus.game_over); else passed++;
    run_tick(1'b1, 1'b0);
    total++; if (int'(dut.state) !== 0) $display("FAIL col_to_idle state %0d exp 0", dut.state); else passed++;
  endtask

  task automatic test_pipe_pass();
    int exp_p;
    apply_reset();
    bus.mode = 1'b0;
    run_tick(1'b1, 1'b0);
    run_tick(1'b0, 1'b1);
    run_tick(1'b0, 1'b1);
    total++; if (int'(dut.bird_y) !== 2) $display("FAIL pass_bird got %0d exp 2", dut.bird_y); else passed++;
    for (int t = 3; t <= 8; t++) begin
      if (t == 3) run_tick(1'b1, 1'b1);
      else        run_tick(1'b0, 1'b0);
      exp_p = (t == 8) ? 7 : 7 - t;
      total++; if (int'(dut.pipe_x) !== exp_p) $display("FAIL pass_pipe tick %0d got %0d exp %0d", t, dut.pipe_x, exp_p); else passed++;
      total++; if (bus.game_over !== 1'b0) $display("FAIL pass_over tick %0d got %b exp 0", t, bus.game_over); else passed++;
    end
    total++; if (int'(dut.bird_y) !== 2) $display("FAIL pass_bird_hold got %0d exp 2", dut.bird_y); else passed++;
    total++; if (bus.score !== 8'd1) $display("FAIL pass_score got %0d exp 1", bus.score); else passed++;
    gap_exp = int'(tick_lf) % 6;
    total++; if (int'(dut.gap_y) !== gap_exp) $display("FAIL pass_gap got %0d exp %0d", dut.gap_y, gap_exp); else passed++;
  endtask

  task automatic test_back_to_back();
    int   b = 2;
    int   exp_p;
    logic up, dn;
    for (int t = 9; t <= 16; t++) begin
      up = (b < gap_exp);
      dn = (b > gap_exp + 2);
      run_tick(up, dn);
      if (up) b = b + 1;
      else if (dn) b = b - 1;
      exp_p = (t == 16) ? 7 : 15 - t;
      total++; if (int'(dut.pipe_x) !== exp_p) $display("FAIL b2b_pipe tick %0d got %0d exp %0d", t, dut.pipe_x, exp_p); else passed++;
      total++; if (bus.game_over !== 1'b0) $display("FAIL b2b_over tick %0d got %b exp 0", t, bus.game_over); else passed++;
    end
    total++; if (int'(dut.bird_y) !== b) $display("FAIL b2b_bird got %0d exp %0d", dut.bird_y, b); else passed++;
    total++; if (bus.score !== 8'd2) $display("FAIL b2b_score got %0d exp 2", bus.score); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp_col;
    rst_n = 1'b1; #1;
    total++; if (bus.score !== 8'd0) $display("FAIL midrst_score got %0d exp 0", bus.score); else passed++;
    total++; if (bus.game_over !== 1'b0) $display("FAIL midrst_over got %b exp 0", bus.game_over); else passed++;
    total++; if (bus.col !== 8'h01) $display("FAIL midrst_col got %h exp 01", bus.col); else passed++;
    #2; rst_n = 1'b0;
    ph = 0; cidx = 0; lf = 8'hA5;
    cycle();
    exp_col = 8'(1) << cidx;
    total++; if (int'(dut.state) !== 0) $display("FAIL midrst_idle state %0d exp 0", dut.state); else passed++;
    total++; if (bus.col !== exp_col) $display("FAIL midrst_col_after got %h exp %h", bus.col, exp_col); else passed++;
  endtask

  task automatic test_freeze();
    logic [7:0] exp_col;
    apply_reset();
    bus.mode = 1'b0;
    run_tick(1'b1, 1'b0);
    run_tick(1'b0, 1'b0);
    cycle(); cycle();
    total++; if (int'(dut.tick_cnt) !== 2) $display("FAIL frz_pre_tick got %0d exp 2", dut.tick_cnt); else passed++;
    bus.ena = 1'b0; bus.btn_up = 1'b1; #1;
    total++; if ({bus.col, bus.row} !== 16'h0000) $display("FAIL frz_blank_now got %h exp 0000", {bus.col, bus.row}); else passed++;
    for (int i = 0; i < 20; i++) begin
      cycle();
      total++; if ({bus.col, bus.row} !== 16'h0000) $display("FAIL frz_blank cycle %0d got %h exp 0000", i, {bus.col, bus.row}); else passed++;
    end
    bus.btn_up = 1'b0;
    total++; if (int'(dut.bird_y) !== 4) $display("FAIL frz_bird got %0d exp 4", dut.bird_y); else passed++;
    total++; if (int'(dut.pipe_x) !== 6) $display("FAIL frz_pipe got %0d exp 6", dut.pipe_x); else passed++;
    total++; if (bus.score !== 8'd0) $display("FAIL frz_score got %0d exp 0", bus.score); else passed++;
    total++; if (int'(dut.tick_cnt) !== 2) $display("FAIL frz_tick got %0d exp 2", dut.tick_cnt); else passed++;
    bus.ena = 1'b1;
    cycle();
    total++; if (int'(dut.pipe_x) !== 6) $display("FAIL frz_resume_early got %0d exp 6", dut.pipe_x); else passed++;
    cycle();
    total++; if (int'(dut.pipe_x) !== 5) $display("FAIL frz_resume_tick got %0d exp 5", dut.pipe_x); else passed++;
    total++; if (int'(dut.bird_y) !== 4) $display("FAIL frz_no_press got %0d exp 4", dut.bird_y); else passed++;
    exp_col = 8'(1) << cidx;
    total++; if (bus.col !== exp_col) $display("FAIL frz_resume_col got %h exp %h", bus.col, exp_col); else passed++;
  endtask

  initial begin
    bus.ena = 1'b1; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.mode = 1'b0;
    test_reset();
    test_manual_saturation();
    test_gravity_fall();
    test_collision();
    test_pipe_pass();
    test_back_to_back();
    test_reset_mid_run();
    test_freeze();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
